// File: rtl/reorder_45_ctrl.sv
// rtl/reorder_45_ctrl.sv - ping-pong 45-point 5x3x3 digit-reversal reorder buffer (optional out_last via REORDER45_LAST_EN)
module reorder_45_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_idx
`ifdef REORDER45_LAST_EN
    ,
    output logic              out_last
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [0:1][0:44];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [5:0]        wr_idx;
    logic [5:0]        rd_idx;
    // Read position kept as its mixed-radix digits k = 9q + 3s + t.
    logic [2:0]        rd_q;
    logic [1:0]        rd_s;
    logic [1:0]        rd_t;
    logic [5:0]        rd_addr;
    logic              wr_fire;
    logic              wr_last;
    logic              rd_last;
    logic              load;

    assign in_ready = rst_n && !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = (wr_idx == 6'd44);
    assign rd_last  = (rd_idx == 6'd44);
    // Digit-reversed address: weights of q, s, t swap to 1, 5, 15.
    assign rd_addr  = 6'(rd_q) + 6'(rd_s) * 6'd5 + 6'(rd_t) * 6'd15;

    // State register for the read sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and load decision; a finished frame chains straight into a full next bank.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                load = !out_valid || out_ready;
                if (load && rd_last) begin
                    state_nx = full[~rd_bank] ? STREAM : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sample storage; contents need no reset since the full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_idx] <= in_data;
        end
    end

    // Write pointer, bank flags; writer and reader always touch different full bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_idx  <= 6'd0;
            full    <= 2'b00;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= 6'd0;
                end else begin
                    wr_idx <= wr_idx + 6'd1;
                end
            end
            if (load && rd_last) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read pointer and output register with hold under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank   <= 1'b0;
            rd_idx    <= 6'd0;
            rd_q      <= 3'd0;
            rd_s      <= 2'd0;
            rd_t      <= 2'd0;
            out_data  <= '0;
            out_idx   <= 6'd0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= mem[rd_bank][rd_addr];
            out_idx   <= rd_idx;
            out_valid <= 1'b1;
            if (rd_last) begin
                rd_bank <= ~rd_bank;
                rd_idx  <= 6'd0;
                rd_q    <= 3'd0;
                rd_s    <= 2'd0;
                rd_t    <= 2'd0;
            end else begin
                rd_idx <= rd_idx + 6'd1;
                if (rd_t == 2'd2) begin
                    rd_t <= 2'd0;
                    if (rd_s == 2'd2) begin
                        rd_s <= 2'd0;
                        rd_q <= rd_q + 3'd1;
                    end else begin
                        rd_s <= rd_s + 2'd1;
                    end
                end else begin
                    rd_t <= rd_t + 2'd1;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef REORDER45_LAST_EN
    // End-of-frame marker registered alongside each load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_last <= 1'b0;
        end else if (load) begin
            out_last <= rd_last;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_45_ctrl.sv
// tb/tb_reorder_45_ctrl.sv - directed self-checking bench for reorder_45_ctrl
module tb_reorder_45_ctrl;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_idx;
`ifdef REORDER45_LAST_EN
    logic              out_last;
`endif

    always #5 clk = ~clk;

    reorder_45_ctrl #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx)
`ifdef REORDER45_LAST_EN
        ,
        .out_last (out_last)
`endif
    );

    // Stored address for each output position, worked out by hand from k = 9q+3s+t -> q+5s+15t.
    int gold [45] = '{ 0, 15, 30,  5, 20, 35, 10, 25, 40,
                       1, 16, 31,  6, 21, 36, 11, 26, 41,
                       2, 17, 32,  7, 22, 37, 12, 27, 42,
                       3, 18, 33,  8, 23, 38, 13, 28, 43,
                       4, 19, 34,  9, 24, 39, 14, 29, 44 };

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] feed  [$];
    logic [DATA_W-1:0] exp_d [$];
    logic [5:0]        exp_i [$];
    logic [DATA_W-1:0] fb    [45];
    int                acc        = 0;
    int                cyc        = 0;
    int                out_mode   = 1;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_d     = '0;
    logic [5:0]        prev_i     = '0;
    int                hs_cnt     = 0;
    int                hs45_cyc   = -1;
    int                first_v    = -1;
    int                run        = 0;
    int                max_run    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        out_ready = (out_mode == 2) ? 1'($urandom_range(0, 1)) : (out_mode == 1);
        in_valid  = (feed.size() > 0);
        in_data   = in_valid ? feed[0] : '0;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_d));
            chk("hold_idx", 32'(out_idx), 32'(prev_i));
        end
        if (out_valid) begin
            run++;
            if (run > max_run) max_run = run;
            if (first_v < 0) first_v = cyc;
`ifdef REORDER45_LAST_EN
            chk("out_last", 32'(out_last), 32'(out_idx == 6'd44));
`endif
        end else begin
            run = 0;
        end
        if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_d.pop_front()));
                chk("out_idx", 32'(out_idx), 32'(exp_i.pop_front()));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_i     = out_idx;
        if (in_valid && in_ready) begin
            fb[acc] = in_data;
            acc++;
            hs_cnt++;
            void'(feed.pop_front());
            if (acc == 45) begin
                for (int k = 0; k < 45; k++) begin
                    exp_d.push_back(fb[gold[k]]);
                    exp_i.push_back(6'(k));
                end
                acc      = 0;
                hs45_cyc = cyc;
            end
        end
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (feed.size() == 0 && exp_d.size() == 0 && !out_valid) break;
        end
        chk({tag, "_left"}, 32'(exp_d.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
`ifdef REORDER45_LAST_EN
        chk("rst_out_last", 32'(out_last), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // One frame, natural data, free-running output.
        out_mode = 1;
        for (int k = 0; k < 45; k++) feed.push_back(16'(k));
        first_v = -1;
        drain("t1", 200);
        chk("t1_latency", 32'(first_v - hs45_cyc), 32'd3);

        // Two frames back to back must stream 90 outputs without a bubble.
        for (int k = 0; k < 45; k++) feed.push_back(16'(k));
        for (int k = 0; k < 45; k++) feed.push_back(16'(100 + k));
        run     = 0;
        max_run = 0;
        drain("t2", 300);
        chk("t2_run", 32'(max_run), 32'd90);

        // Full back-pressure: both banks fill, then the input stalls.
        out_mode = 0;
        hs_cnt   = 0;
        for (int k = 0; k < 100; k++) feed.push_back(16'(1000 + k));
        repeat (150) cycle();
        chk("t3_accepted", 32'(hs_cnt), 32'd90);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_out_data", 32'(out_data), 32'd1000);
        feed.delete();
        out_mode = 1;
        drain("t3", 400);
        chk("t3_in_ready_after", 32'(in_ready), 32'd1);

        // Random output back-pressure over two frames.
        out_mode = 2;
        for (int k = 0; k < 90; k++) feed.push_back(16'(2000 + k));
        drain("t4", 2000);

        // Reset after a partial frame discards it.
        out_mode = 1;
        for (int k = 0; k < 20; k++) feed.push_back(16'(3000 + k));
        repeat (22) cycle();
        chk("t5_partial", 32'(acc), 32'd20);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        acc        = 0;
        prev_stall = 1'b0;
        exp_d.delete();
        exp_i.delete();
        for (int k = 0; k < 45; k++) feed.push_back(16'(4000 + k));
        drain("t5", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
